rca_4bit: RTL and testbench

- Registered 4-bit unsigned ripple-carry adder: sum = a + b, with carry-out.
- Built from a chain of single-bit full adders; carry ripples LSB to MSB.
- Result is captured in an output register, so it presents a clean, clocked sum/carry to downstream datapath logic.
- Width is parameterised; the default of 4 is the shipped configuration.

---
 rtl/rca_pkg.sv | 12 +
 rtl/full_adder.sv | 16 +
 rtl/rca_4bit.sv | 62 ++++++
 tb/tb_rca_4bit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package rca_pkg;

  localparam int RCA_WIDTH = 4;

  // Full-precision result of an RCA_WIDTH-bit addition, carry in the top bit.
  typedef struct packed {
    logic                 cout;
    logic [RCA_WIDTH-1:0] sum;
  } rca_result_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; one stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca_4bit.sv
// Registered WIDTH-bit ripple-carry adder with one-cycle latency.
// Optional macro RCA_OVERFLOW_EN adds a registered two's-complement overflow flag (ovf).
module rca_4bit
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // Carry ripples strictly LSB to MSB; no lookahead.
  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef RCA_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: arithmetic reference model checked every cycle,
// plus hand-computed directed vectors, exhaustive sweep and randomized traffic.
module tb_rca_4bit;
  import rca_pkg::*;

  localparam int W = RCA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
`ifdef RCA_OVERFLOW_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  rca_4bit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
`ifdef RCA_OVERFLOW_EN
    .ovf      (ovf),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the sampled operands.
  rca_result_t m_res;
  logic        m_valid;
  logic        m_ovf;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    rca_result_t r;
    r = rca_result_t'({1'b0, a} + {1'b0, b});
    if (rst) begin
      m_res   <= '0;
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_res <= r;
        // Signed overflow: operands share a sign that the result does not.
        m_ovf <= (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
      end
    end
    cmp_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_sum", 32'(sum), 32'(m_res.sum));
      check("model_cout", 32'(cout), 32'(m_res.cout));
      check("model_valid", 32'(out_valid), 32'(m_valid));
`ifdef RCA_OVERFLOW_EN
      check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // Drive one input set for one edge, then check outputs against literals.
  task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tv,
                      input logic [W-1:0] es, input logic ec, input logic ev, input string nm);
    a = ta; b = tb_v; in_valid = tv;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_sum"}, 32'(sum), 32'(es));
    check({nm, "_cout"}, 32'(cout), 32'(ec));
    check({nm, "_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 4'b1111; b = 4'b0001;

    // Reset held two cycles with valid input present.
    step(4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, "rst0");
    step(4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, "rst1");
    rst = 1'b0;

    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, "zero");
    step(4'b0001, 4'b0010, 1'b1, 4'b0011, 1'b0, 1'b1, "one_two");
    step(4'b0101, 4'b0011, 1'b1, 4'b1000, 1'b0, 1'b1, "ripple3");
    step(4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1, "wrap");
    step(4'b1111, 4'b1111, 1'b1, 4'b1110, 1'b1, 1'b1, "allones");
    step(4'b1010, 4'b0111, 1'b1, 4'b0001, 1'b1, 1'b1, "a_plus_7");
    step(4'b0011, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b0, "hold0");
    step(4'b1100, 4'b1100, 1'b0, 4'b0001, 1'b1, 1'b0, "hold1");

`ifdef RCA_OVERFLOW_EN
    step(4'b0111, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b1, "ovf_pos");
    check("ovf_pos_flag", 32'(ovf), 32'd1);
    step(4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1, "ovf_neg");
    check("ovf_neg_flag", 32'(ovf), 32'd0);
`endif

    // Result in flight when reset arrives is discarded.
    a = 4'b0110; b = 4'b0110; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_flight_sum", 32'(sum), 32'd0);
    check("rst_flight_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Exhaustive back-to-back sweep; the model checks every cycle.
    for (int i = 0; i < (1 << (2 * W)); i++) begin
      a = W'(i >> W); b = W'(i); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end

    // Randomized traffic with sparse valid and occasional reset.
    for (int i = 0; i < 400; i++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
